pdm_multi_wave_gen: RTL and testbench

Multi-channel PDM test-pattern generator for the mic-array datapath. It plays a wavetable of packed PDM words out MSB-first on a generated PDM bit clock. Each output channel takes the same bitstream through its own programmable delay, so the block can stand in for a physical microphone array with known arrival-time skews. It feeds the PDM capture/decimation chain in simulation and in on-board loopback tests.

---
 rtl/pdm_gen_pkg.sv | 26 ++
 rtl/pdm_wavetable.sv | 39 +++
 rtl/pdm_multi_wave_gen.sv | 246 ++++++++++++++++++++++++
 tb/tb_pdm_multi_wave_gen.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pdm_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pdm_gen_pkg
// Description : Shared types and constants for the PDM test-pattern generator.
//               Holds the playback state encoding, the LFSR seed and feedback
//               taps, and the default divider/delay settings.
// Revision    : 1.0 - initial release
// ============================================================================
package pdm_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PRIME    = 2'd1,
        ST_RUN      = 2'd2,
        ST_STOPPING = 2'd3
    } state_e;

    // Galois form of x^16 + x^14 + x^13 + x^11 + 1, right-shifting.
    localparam logic [15:0] c_lfsr_seed = 16'hACE1;
    localparam logic [15:0] c_lfsr_taps = 16'hB400;

    localparam int c_def_clk_div   = 10;
    localparam int c_def_max_delay = 63;

endpackage
`default_nettype wire

// File: rtl/pdm_wavetable.sv
`default_nettype none
// ============================================================================
// Module      : pdm_wavetable
// Description : Synchronous single-port ROM, 1-cycle read latency. Contents
//               come from INIT_DATA (word 0 in the least-significant WORD_W
//               bits), normally generated from the wavetable hex file by the
//               build flow. Addresses at or above DEPTH read as zero.
// Ports       : clk     - system clock
//               address - read address, registered on every clock
//               q       - word at the address of the previous clock
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_wavetable #(
    parameter int                      DEPTH     = 1000,
    parameter int                      ADDR_W    = 14,
    parameter int                      WORD_W    = 8,
    parameter logic [DEPTH*WORD_W-1:0] INIT_DATA = '0
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] address,
    output logic [WORD_W-1:0] q
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    for (genvar i = 0; i < 2**ADDR_W; i++) begin : g_mem
        if (i < DEPTH) begin : g_used
            assign mem[i] = INIT_DATA[i*WORD_W +: WORD_W];
        end else begin : g_unused
            assign mem[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        q <= mem[address];
    end

endmodule
`default_nettype wire

// File: rtl/pdm_multi_wave_gen.sv
`default_nettype none
// ============================================================================
// Module      : pdm_multi_wave_gen
// Description : Multi-channel PDM test-pattern generator. Plays a wavetable
//               MSB-first on a divided PDM bit clock; every channel carries
//               the same stream through its own programmable bit delay.
// Ports       : clk/reset_n      - clock, async active-low reset
//               start/stop/loop  - playback control pulses and loop mode
//               cfg_we/cfg_ch/cfg_delay - per-channel delay write port
//               pdm_clk/pdm_data - PDM bit clock and per-channel data
//               busy/wrap        - activity flag and last-word-loaded pulse
//               src_sel          - (PDM_GEN_LFSR_EN only) 1 = LFSR source
// Config      : define PDM_GEN_LFSR_EN to add the LFSR source and src_sel.
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_multi_wave_gen
    import pdm_gen_pkg::*;
#(
    parameter int                      NUM_CH    = 8,
    parameter int                      WORD_W    = 8,
    parameter int                      DEPTH     = 1000,
    parameter int                      ADDR_W    = 14,
    parameter int                      CLK_DIV   = c_def_clk_div,
    parameter int                      MAX_DELAY = c_def_max_delay,
    parameter logic [DEPTH*WORD_W-1:0] INIT_DATA = '0
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic                             stop,
    input  logic                             loop,
`ifdef PDM_GEN_LFSR_EN
    input  logic                             src_sel,
`endif
    input  logic                             cfg_we,
    input  logic [$clog2(NUM_CH)-1:0]        cfg_ch,
    input  logic [$clog2(MAX_DELAY+1)-1:0]   cfg_delay,
    output logic                             pdm_clk,
    output logic [NUM_CH-1:0]                pdm_data,
    output logic                             busy,
    output logic                             wrap
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int DLY_W = $clog2(MAX_DELAY+1);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(WORD_W);

    // Reset asserts asynchronously, releases two clocks after reset_n rises.
    logic [1:0] rst_sync_q;
    logic       rst_n_sync;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n_sync = rst_sync_q[1];

    state_e                 state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [WORD_W-1:0]      word_q, word_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [MAX_DELAY-1:0]   hist_q, hist_d;
    logic                   loop_q, loop_d;
    logic                   last_q, last_d;
    logic                   wrap_q, wrap_d;
    logic                   pdm_clk_q, pdm_clk_d;
    logic [NUM_CH-1:0]      pdm_data_q, pdm_data_d;
    logic [DLY_W-1:0]       delay_q [NUM_CH];
    logic [WORD_W-1:0]      rom_q;
    logic                   strobe;
    logic                   shift_en;
    logic                   src_bit;
    logic [MAX_DELAY:0]     hist_shift;
    logic [DLY_W-1:0]       cfg_delay_clamped;
`ifdef PDM_GEN_LFSR_EN
    logic [15:0]            lfsr_q, lfsr_d;
    logic                   src_sel_q, src_sel_d;
`endif

    // Read address is the next-state address so the fetch of word N+1
    // issues in the same cycle word N is loaded.
    pdm_wavetable #(
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W),
        .WORD_W    (WORD_W),
        .INIT_DATA (INIT_DATA)
    ) u_rom (
        .clk     (clk),
        .address (addr_d),
        .q       (rom_q)
    );

    assign strobe = (div_q == '0);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_d      = bit_q;
        word_d     = word_q;
        addr_d     = addr_q;
        hist_d     = hist_q;
        loop_d     = loop_q;
        last_d     = last_q;
        wrap_d     = 1'b0;
        shift_en   = 1'b0;
        src_bit    = 1'b0;
`ifdef PDM_GEN_LFSR_EN
        lfsr_d     = lfsr_q;
        src_sel_d  = src_sel_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_PRIME;
                    loop_d    = loop;
`ifdef PDM_GEN_LFSR_EN
                    src_sel_d = src_sel;
`endif
                end
            end
            ST_PRIME: begin
                // bit_d = 0 makes the first RUN strobe a word boundary.
                state_d = ST_RUN;
                div_d   = '0;
                bit_d   = '0;
                addr_d  = '0;
                hist_d  = '0;
                last_d  = 1'b0;
`ifdef PDM_GEN_LFSR_EN
                lfsr_d  = c_lfsr_seed;
`endif
            end
            ST_RUN, ST_STOPPING: begin
                div_d = (div_q == DIV_W'(CLK_DIV-1)) ? '0 : div_q + DIV_W'(1);
                if (state_q == ST_RUN && stop) state_d = ST_STOPPING;
                if (strobe) begin
                    if (bit_q == '0) begin
                        if (state_q == ST_STOPPING || last_q) begin
                            state_d = ST_IDLE;
                        end else begin
                            shift_en = 1'b1;
                            word_d   = rom_q;
                            bit_d    = BIT_W'(WORD_W-1);
                            src_bit  = rom_q[WORD_W-1];
                            if (addr_q == ADDR_W'(DEPTH-1)) begin
                                addr_d = '0;
                                wrap_d = 1'b1;
                                last_d = !loop_q;
                            end else begin
                                addr_d = addr_q + ADDR_W'(1);
                            end
                        end
                    end else begin
                        shift_en = 1'b1;
                        bit_d    = bit_q - BIT_W'(1);
                        src_bit  = word_q[bit_d];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef PDM_GEN_LFSR_EN
        if (shift_en && src_sel_q) begin
            src_bit = lfsr_q[0];
            lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? c_lfsr_taps : 16'h0000);
        end
`endif

        // hist_shift[k] is the source bit from k strobes ago, counting the
        // one emitted now as k = 0.
        hist_shift = {hist_q, src_bit};
        if (shift_en) hist_d = hist_shift[MAX_DELAY-1:0];

        pdm_data_d = pdm_data_q;
        if (shift_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                pdm_data_d[c] = hist_shift[delay_q[c]];
            end
        end
        if (state_d == ST_IDLE) pdm_data_d = '0;

        pdm_clk_d = (state_d == ST_RUN || state_d == ST_STOPPING) &&
                    (div_d >= DIV_W'(CLK_DIV/2));
    end

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            bit_q      <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            hist_q     <= '0;
            loop_q     <= 1'b0;
            last_q     <= 1'b0;
            wrap_q     <= 1'b0;
            pdm_clk_q  <= 1'b0;
            pdm_data_q <= '0;
`ifdef PDM_GEN_LFSR_EN
            lfsr_q     <= c_lfsr_seed;
            src_sel_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            hist_q     <= hist_d;
            loop_q     <= loop_d;
            last_q     <= last_d;
            wrap_q     <= wrap_d;
            pdm_clk_q  <= pdm_clk_d;
            pdm_data_q <= pdm_data_d;
`ifdef PDM_GEN_LFSR_EN
            lfsr_q     <= lfsr_d;
            src_sel_q  <= src_sel_d;
`endif
        end
    end

    // Out-of-range requests saturate; channel indices with no matching
    // channel simply match nothing.
    assign cfg_delay_clamped = (int'(cfg_delay) > MAX_DELAY) ? DLY_W'(MAX_DELAY)
                                                              : cfg_delay;

    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            for (int c = 0; c < NUM_CH; c++) delay_q[c] <= '0;
        end else if (cfg_we) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (cfg_ch == CH_W'(c)) delay_q[c] <= cfg_delay_clamped;
            end
        end
    end

    assign pdm_clk  = pdm_clk_q;
    assign pdm_data = pdm_data_q;
    assign busy     = (state_q != ST_IDLE);
    assign wrap     = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_pdm_multi_wave_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pdm_multi_wave_gen
// Description : Directed self-checking bench for pdm_multi_wave_gen. Uses a
//               4-word table (A5 0F FF 00). Five channels so that an
//               out-of-range channel index fits the 3-bit cfg_ch port, and
//               MAX_DELAY = 40 so an over-range delay fits the 6-bit port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pdm_multi_wave_gen;

    localparam int NCH  = 5;
    localparam int MAXD = 40;

    logic            clk       = 1'b0;
    logic            reset_n   = 1'b0;
    logic            start     = 1'b0;
    logic            stop      = 1'b0;
    logic            loop      = 1'b0;
    logic            src_sel   = 1'b0;
    logic            cfg_we    = 1'b0;
    logic [2:0]      cfg_ch    = 3'd0;
    logic [5:0]      cfg_delay = 6'd0;
    logic            pdm_clk;
    logic [NCH-1:0]  pdm_data;
    logic            busy;
    logic            wrap;

    int checks   = 0;
    int errors   = 0;
    int wrap_cnt = 0;
    int w0;

    logic [7:0] tbl [4] = '{8'hA5, 8'h0F, 8'hFF, 8'h00};
    logic       sbits [128];
    int         dly_m [NCH];

    pdm_multi_wave_gen #(
        .NUM_CH    (NCH),
        .WORD_W    (8),
        .DEPTH     (4),
        .ADDR_W    (2),
        .CLK_DIV   (10),
        .MAX_DELAY (MAXD),
        .INIT_DATA (32'h00FF0FA5)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .stop      (stop),
        .loop      (loop),
`ifdef PDM_GEN_LFSR_EN
        .src_sel   (src_sel),
`endif
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_delay (cfg_delay),
        .pdm_clk   (pdm_clk),
        .pdm_data  (pdm_data),
        .busy      (busy),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wrap === 1'b1) wrap_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_table();
        for (int i = 0; i < 128; i++) begin
            logic [7:0] w;
            w = tbl[(i / 8) % 4];
            sbits[i] = w[7 - (i % 8)];
        end
    endtask

    task automatic fill_lfsr();
        logic [15:0] l;
        l = 16'hACE1;
        for (int i = 0; i < 128; i++) begin
            sbits[i] = l[0];
            l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
        end
    endtask

    function automatic logic [NCH-1:0] exp_data(input int n);
        logic [NCH-1:0] r;
        r = '0;
        for (int c = 0; c < NCH; c++) begin
            if (n - dly_m[c] >= 0) r[c] = sbits[n - dly_m[c]];
        end
        return r;
    endfunction

    task automatic cfg(input int ch, input int d);
        tick();
        cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_delay = 6'(d);
        tick();
        cfg_we = 1'b0;
    endtask

    // Returns 1 ns after the first edge at which bit 0 is on pdm_data.
    task automatic launch(input logic l, input logic with_stop);
        tick();
        start = 1'b1; loop = l; stop = with_stop;
        tick();
        start = 1'b0; stop = 1'b0;
        check("busy_in_prime", 64'(busy), 64'd1);
        tick();
        tick();
    endtask

    // One PDM bit cell: data + low clock at its start, high clock mid-cell.
    task automatic bit_cell(input int n, input logic do_stop, input logic do_start);
        check($sformatf("bit%0d_clk_data", n), 64'({pdm_clk, pdm_data}),
              64'({1'b0, exp_data(n)}));
        stop = do_stop; start = do_start;
        tick();
        stop = 1'b0; start = 1'b0;
        repeat (3) tick();
        check($sformatf("bit%0d_clk_high", n), 64'(pdm_clk), 64'd1);
        repeat (6) tick();
    endtask

    initial begin
        // Reset and idle
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle_outputs", 64'({pdm_clk, busy, wrap, pdm_data}), 64'd0);
        end

        // Single play, all delays 0
        fill_table();
        for (int c = 0; c < NCH; c++) dly_m[c] = 0;
        w0 = wrap_cnt;
        launch(1'b0, 1'b0);
        for (int n = 0; n < 32; n++) bit_cell(n, 1'b0, 1'b0);
        check("single_end_idle", 64'({busy, pdm_clk, pdm_data}), 64'd0);
        check("single_wrap_count", 64'(wrap_cnt - w0), 64'd1);

        // Delays 0/1/5/clamped, out-of-range channel write ignored
        cfg(0, 0);
        cfg(1, 1);
        cfg(2, 5);
        cfg(3, 60);
        cfg(5, 3);
        dly_m[0] = 0; dly_m[1] = 1; dly_m[2] = 5; dly_m[3] = MAXD; dly_m[4] = 0;
        w0 = wrap_cnt;
        launch(1'b1, 1'b0);
        for (int n = 0; n < 88; n++) bit_cell(n, n == 82, 1'b0);
        check("stop_end_idle", 64'({busy, pdm_clk, pdm_data}), 64'd0);
        check("loop_wrap_count", 64'(wrap_cnt - w0), 64'd2);

        // start+stop together in IDLE starts; start during RUN ignored
        w0 = wrap_cnt;
        launch(1'b0, 1'b1);
        for (int n = 0; n < 32; n++) bit_cell(n, 1'b0, n == 3);
        check("ignored_start_end", 64'({busy, pdm_data}), 64'd0);
        check("ignored_start_wrap", 64'(wrap_cnt - w0), 64'd1);

        // Asynchronous reset mid-word
        launch(1'b1, 1'b0);
        bit_cell(0, 1'b0, 1'b0);
        bit_cell(1, 1'b0, 1'b0);
        repeat (5) tick();
        check("pre_reset_state", 64'({pdm_clk, busy, pdm_data[0]}), 64'b111);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_outputs", 64'({pdm_clk, busy, wrap, pdm_data}), 64'd0);
        repeat (3) tick();
        #3 reset_n = 1'b1;
        repeat (4) tick();

        // Delays cleared by reset; stop early in word 1
        for (int c = 0; c < NCH; c++) dly_m[c] = 0;
        launch(1'b0, 1'b0);
        for (int n = 0; n < 16; n++) bit_cell(n, n == 8, 1'b0);
        check("stop_word1_idle", 64'({busy, pdm_clk, pdm_data}), 64'd0);

`ifdef PDM_GEN_LFSR_EN
        fill_lfsr();
        src_sel = 1'b1;
        launch(1'b0, 1'b0);
        src_sel = 1'b0;
        for (int n = 0; n < 24; n++) bit_cell(n, n == 17, 1'b0);
        check("lfsr_end_idle", 64'({busy, pdm_data}), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
